mul_div_engine: RTL and testbench
=================================

Name: mul_div_engine

Overview:
- Iterative multi-cycle integer multiplier/divider serving the RV32M execution unit.
- Accepts one operation per start pulse and returns a 2*SIZE-bit result with a one-cycle ready pulse.
- The surrounding control unit handles ROB tagging and broadcast; this block does arithmetic only.

Parameters:
SIZE, 32, operand width in bits (even, >= 4)

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any in-flight operation
start  in  1  sample operands/controls this edge (honoured only in IDLE)
mul_div  in  1  1 = multiply, 0 = divide
num1_signed  in  1  1 = num1 is two's complement
num2_signed  in  1  1 = num2 is two's complement
num1  in  SIZE  multiplicand / dividend
num2  in  SIZE  multiplier / divisor
result  out  2*SIZE  multiply: full product; divide: {remainder, quotient}
ready  out  1  one-cycle pulse, result valid

Behaviour:
- Reset: state IDLE, result = 0, ready = 0, all internal registers 0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE -> PREP: on start && !flush.
  - Latch mul_div, both signed flags and both operands; inputs are not used afterwards.
- PREP:
  - Record each operand's sign (MSB & signed flag).
  - Replace negative operands with their magnitudes.
  - Clear the accumulator and the iteration counter.
  - -> CALC.
- CALC, SIZE iterations, one per cycle:
  - Multiply: shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
  - -> FIX after the last iteration.
- FIX:
  - Multiply: negate the 2*SIZE product if sign1 XOR sign2.
  - Divide: negate the quotient if sign1 XOR sign2; the remainder takes the dividend's sign.
  - Register the value into result. -> DONE.
- DONE: ready = 1 for exactly this cycle. -> IDLE.
- Latency: start sampled at edge 0; ready is high in the cycle after edge SIZE+2 (34 for SIZE=32).
- result holds its value until the next FIX. ready is registered.
- Divide by zero: quotient = all ones; remainder = num1 unmodified (any signedness).
- Signed overflow (most negative / -1, both signed): quotient = most negative value, remainder = 0.
- Both special cases are still reported at the normal latency.
- start outside IDLE is ignored, with no queuing.
- flush in any state: next state IDLE, ready forced 0 that cycle, result unchanged, pending operation discarded.
- flush and start on the same edge: flush wins, nothing starts.
- Asynchronous reset mid-operation: immediate return to reset values.
- Signed flags apply per operand, independently; mixed signedness (MULHSU) is legal.

Optional Feature:
MUL_BOOTH_EN
- Defined: multiplies use radix-4 Booth recoding in CALC.
  - SIZE/2 iterations; ready in the cycle after edge SIZE/2+2.
  - Signed operands are handled by the recoding, not by magnitude conversion.
  - Unsigned operands are zero-extended by 2 bits.
  - Products are bit-identical to the default path.
- Undefined: shift-add multiply only.
- Division is unaffected either way.

Decomposition:
- Package mul_div_pkg holds:
  - the state enum type;
  - a localparam for the iteration count;
  - the all-ones divide-by-zero quotient constant.
- Single module, no sub-module.
- The Booth recoder is a function in the package, compiled only under MUL_BOOTH_EN.

Test Plan:
- Unsigned mul 3 x 5 -> result 64'h0000_0000_0000_000F; ready one cycle, after edge 34; later start ignored while busy.
- Signed mul FFFFFFFE x 00000003 -> FFFFFFFF_FFFFFFFA.
- Mixed and unsigned mul:
  - num1 signed FFFFFFFF x num2 unsigned FFFFFFFF -> FFFFFFFF_00000001.
  - Both unsigned, same operands -> FFFFFFFE_00000001.
- Signed div FFFFFFF9 / 00000002 -> FFFFFFFF_FFFFFFFD (rem -1, quot -3).
- Unsigned div 00000064 / 0 -> 00000064_FFFFFFFF.
- Signed div 80000000 / FFFFFFFF -> 00000000_80000000.
- Flush mid-operation:
  - Flush on edge 10 of a multiply -> no ready pulse, result unchanged.
  - Next start 6 x 7 -> 00000000_0000002A at normal latency.
  - Repeat the full suite with MUL_BOOTH_EN defined; ready must come after edge 18.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide engine.
// MUL_BOOTH_EN selects radix-4 Booth multiply (two product bits per step).
package mul_div_pkg;

   localparam int DEF_SIZE = 32;
   localparam int MAX_SIZE = 128;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } state_t;

   // Product bits retired per CALC cycle; sets the multiply iteration count
   // (SIZE / MUL_STEP). Division always retires one quotient bit per cycle.
`ifdef MUL_BOOTH_EN
   localparam int MUL_STEP = 2;
`else
   localparam int MUL_STEP = 1;
`endif

   // Quotient returned on divide by zero, sliced to SIZE by the user.
   localparam logic [MAX_SIZE-1:0] DIV0_QUOT = '1;

`ifdef MUL_BOOTH_EN
   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_t;

   // Radix-4 digit from {y[2i+1], y[2i], y[2i-1]}: one of 0, +-1, +-2.
   function automatic booth_t booth_rec(input logic [2:0] t);
      booth_t d;
      d = '0;
      unique case (t)
         3'b001, 3'b010: d.one = 1'b1;
         3'b011:         d.two = 1'b1;
         3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
         3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
         default:        d = '0;
      endcase
      return d;
   endfunction
`endif

endpackage

// File: rtl/mul_div_engine.sv
// Iterative integer multiplier/divider: start in IDLE, one-cycle ready pulse.
// Ports: clk, rstn (async low), flush, start, mul_div, num1/num2 + signed
// flags in; result {rem,quot} or product and ready out. Macro: MUL_BOOTH_EN.
module mul_div_engine
   import mul_div_pkg::*;
#(
   parameter int SIZE = DEF_SIZE
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              start,
   input  logic              mul_div,
   input  logic              num1_signed,
   input  logic              num2_signed,
   input  logic [SIZE-1:0]   num1,
   input  logic [SIZE-1:0]   num2,
   output logic [2*SIZE-1:0] result,
   output logic              ready
);

   localparam int W  = 2 * SIZE;
   localparam int CW = $clog2(SIZE) + 1;

   localparam logic [CW-1:0] LAST_MUL = CW'(SIZE / MUL_STEP - 1);
   localparam logic [CW-1:0] LAST_DIV = CW'(SIZE - 1);

   localparam logic [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};
   localparam logic [SIZE-1:0] DIV0_Q   = DIV0_QUOT[SIZE-1:0];

   state_t state_q, state_d;

   logic            op_mul, f1, f2;
   logic            sign1, sign2;
   logic [SIZE-1:0] n1, n2;
   logic [SIZE-1:0] a, b;
   logic [W-1:0]    acc;
   logic [CW-1:0]   cnt;

   logic            neg1, neg2, last_iter;
   logic [SIZE-1:0] mag1, mag2;

   // Divide step: a = divisor magnitude, b shifts the dividend out of its
   // top and the quotient into its bottom, acc[W-1:SIZE] is the remainder.
   logic [SIZE:0]   r_sh, r_sub;
   logic            r_ge;
   logic [SIZE-1:0] rem_d, rem_q;

   logic [W-1:0]    fix_val;

`ifdef MUL_BOOTH_EN
   logic [W-1:0]    mc;
   logic            y_prev;
   booth_t          bsel;
   logic [W-1:0]    pp_mag, pp;
`else
   logic [SIZE:0]   m_sum;
`endif

   assign neg1      = n1[SIZE-1] & f1;
   assign neg2      = n2[SIZE-1] & f2;
   assign mag1      = neg1 ? -n1 : n1;
   assign mag2      = neg2 ? -n2 : n2;
   assign last_iter = cnt == (op_mul ? LAST_MUL : LAST_DIV);

   assign rem_q = acc[W-1:SIZE];
   assign r_sh  = {rem_q, b[SIZE-1]};
   assign r_sub = r_sh - {1'b0, a};
   // rem < divisor holds every step, so the subtract never leaves SIZE+1
   // signed range and its top bit is the borrow.
   assign r_ge  = ~r_sub[SIZE];
   assign rem_d = r_ge ? r_sub[SIZE-1:0] : r_sh[SIZE-1:0];

`ifdef MUL_BOOTH_EN
   // mc is the sign/zero-extended multiplicand, pre-shifted to the current
   // digit weight; b shifts the raw multiplier right two bits per step.
   assign bsel   = booth_rec({b[1], b[0], y_prev});
   assign pp_mag = bsel.two ? (mc << 1) : (bsel.one ? mc : '0);
   assign pp     = bsel.neg ? -pp_mag : pp_mag;
`else
   // Shift-add: high half accumulates, product bits enter from the top.
   assign m_sum = {1'b0, acc[W-1:SIZE]} + (b[0] ? {1'b0, a} : '0);
`endif

   always_comb begin
      fix_val = acc;
      if (op_mul) begin
`ifdef MUL_BOOTH_EN
         // SIZE/2 digits read y[SIZE-1] as a sign bit; for an unsigned
         // multiplier with that bit set, add back M * 2^SIZE (mc by now).
         fix_val = acc + ((!f2 && n2[SIZE-1]) ? mc : '0);
`else
         fix_val = (sign1 ^ sign2) ? -acc : acc;
`endif
      end else if (n2 == '0) begin
         fix_val = {n1, DIV0_Q};
      end else if (f1 && f2 && n1 == MOST_NEG && n2 == '1) begin
         fix_val = {{SIZE{1'b0}}, MOST_NEG};
      end else begin
         fix_val = {sign1 ? -rem_q : rem_q,
                    (sign1 ^ sign2) ? -b : b};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = PREP;
         PREP:    state_d = CALC;
         CALC:    if (last_iter) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         op_mul <= 1'b0;
         f1     <= 1'b0;
         f2     <= 1'b0;
         sign1  <= 1'b0;
         sign2  <= 1'b0;
         n1     <= '0;
         n2     <= '0;
         a      <= '0;
         b      <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
         ready  <= 1'b0;
`ifdef MUL_BOOTH_EN
         mc     <= '0;
         y_prev <= 1'b0;
`endif
      end else if (flush) begin
         ready <= 1'b0;
      end else begin
         ready <= (state_q == FIX);
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  op_mul <= mul_div;
                  f1     <= num1_signed;
                  f2     <= num2_signed;
                  n1     <= num1;
                  n2     <= num2;
               end
            end
            PREP: begin
               sign1 <= neg1;
               sign2 <= neg2;
               acc   <= '0;
               cnt   <= '0;
               if (op_mul) begin
`ifdef MUL_BOOTH_EN
                  mc     <= {{SIZE{neg1}}, n1};
                  b      <= n2;
                  y_prev <= 1'b0;
`else
                  a <= mag1;
                  b <= mag2;
`endif
               end else begin
                  a <= mag2;
                  b <= mag1;
               end
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (op_mul) begin
`ifdef MUL_BOOTH_EN
                  acc    <= acc + pp;
                  mc     <= mc << 2;
                  b      <= b >> 2;
                  y_prev <= b[1];
`else
                  acc <= {m_sum, acc[SIZE-1:1]};
                  b   <= b >> 1;
`endif
               end else begin
                  acc[W-1:SIZE] <= rem_d;
                  b             <= {b[SIZE-2:0], r_ge};
               end
            end
            FIX: result <= fix_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_engine.sv
// Self-checking bench for mul_div_engine against a 64-bit arithmetic model.
// Honours MUL_BOOTH_EN for the expected multiply latency.
module tb_mul_div_engine;

   localparam int DIV_LAT = 34;
`ifdef MUL_BOOTH_EN
   localparam int MUL_LAT = 18;
`else
   localparam int MUL_LAT = 34;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush;
   logic        start;
   logic        mul_div;
   logic        num1_signed;
   logic        num2_signed;
   logic [31:0] num1;
   logic [31:0] num2;
   logic [63:0] result;
   logic        ready;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] last_exp = '0;

   always #5 clk = ~clk;

   mul_div_engine #(.SIZE(32)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .flush       (flush),
      .start       (start),
      .mul_div     (mul_div),
      .num1_signed (num1_signed),
      .num2_signed (num2_signed),
      .num1        (num1),
      .num2        (num2),
      .result      (result),
      .ready       (ready)
   );

   function automatic logic [63:0] model(input bit m, input bit s1,
                                         input bit s2,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      longint sx, sy, q, r;
      logic [63:0] p, qv, rv;
      sx = s1 ? longint'($signed(x)) : longint'({32'b0, x});
      sy = s2 ? longint'($signed(y)) : longint'({32'b0, y});
      if (m) begin
         p = sx * sy;
         return p;
      end
      if (y == 32'h0) return {x, 32'hFFFF_FFFF};
      if (s1 && s2 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return {32'h0, 32'h8000_0000};
      q  = sx / sy;
      r  = sx % sy;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Issue one operation; returns result at the ready pulse, the edge
   // index of that pulse (-1 on timeout) and whether it lasted one cycle.
   task automatic do_op(input bit m, input bit s1, input bit s2,
                        input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] r, output int lat,
                        output bit one_shot);
      @(negedge clk);
      mul_div     = m;
      num1_signed = s1;
      num2_signed = s2;
      num1        = x;
      num2        = y;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      mul_div     = ~m;
      num1_signed = ~s1;
      num2_signed = ~s2;
      num1        = $urandom;
      num2        = $urandom;
      lat         = -1;
      r           = '0;
      one_shot    = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = k;
            r   = result;
            break;
         end
      end
      if (lat > 0) begin
         @(negedge clk);
         one_shot = !ready;
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (result !== 64'h0) begin
         n_fail++;
         $display("FAIL reset_result: got %h want 0", result);
      end
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b want 0", ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ready: got %b want 0", ready);
      end
   endtask

   typedef struct packed {
      bit          m;
      bit          s1;
      bit          s2;
      logic [31:0] x;
      logic [31:0] y;
      logic [63:0] e;
   } vec_t;

   task automatic test_directed();
      vec_t        v [8];
      logic [63:0] r;
      int          lat, want;
      bit          os;
      v = '{
         '{1'b1, 1'b0, 1'b0, 32'h3, 32'h5, 64'h0000_0000_0000_000F},
         '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'h3,
           64'hFFFF_FFFF_FFFF_FFFA},
         '{1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFF_0000_0001},
         '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           64'hFFFF_FFFE_0000_0001},
         '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2,
           64'hFFFF_FFFF_FFFF_FFFD},
         '{1'b0, 1'b0, 1'b0, 32'h64, 32'h0, 64'h0000_0064_FFFF_FFFF},
         '{1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h0000_0000_8000_0000},
         '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0,
           64'hFFFF_FFF0_FFFF_FFFF}
      };
      for (int i = 0; i < 8; i++) begin
         do_op(v[i].m, v[i].s1, v[i].s2, v[i].x, v[i].y, r, lat, os);
         want = v[i].m ? MUL_LAT : DIV_LAT;
         n_checks++;
         if (r !== v[i].e) begin
            n_fail++;
            $display("FAIL directed_%0d result: got %h want %h",
                     i, r, v[i].e);
         end
         n_checks++;
         if (lat != want) begin
            n_fail++;
            $display("FAIL directed_%0d latency: got %0d want %0d",
                     i, lat, want);
         end
         n_checks++;
         if (!os) begin
            n_fail++;
            $display("FAIL directed_%0d pulse: got %b want 1", i, os);
         end
         last_exp = v[i].e;
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (result !== last_exp) begin
         n_fail++;
         $display("FAIL result_hold: got %h want %h", result, last_exp);
      end
   endtask

   task automatic test_busy_ignore();
      int lat, pulses;
      @(negedge clk);
      mul_div     = 1'b1;
      num1_signed = 1'b0;
      num2_signed = 1'b0;
      num1        = 32'h3;
      num2        = 32'h5;
      start       = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      lat    = -1;
      pulses = 0;
      for (int k = 1; k <= 90; k++) begin
         @(negedge clk);
         if (ready) begin
            pulses++;
            if (lat < 0) lat = k;
         end
         if (k == 5) begin
            mul_div = 1'b0;
            num1    = 32'h63;
            num2    = 32'h1;
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      n_checks++;
      if (result !== 64'hF) begin
         n_fail++;
         $display("FAIL busy_result: got %h want %h", result, 64'hF);
      end
      n_checks++;
      if (lat != MUL_LAT) begin
         n_fail++;
         $display("FAIL busy_latency: got %0d want %0d", lat, MUL_LAT);
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL busy_pulses: got %0d want 1", pulses);
      end
      last_exp = 64'hF;
   endtask

   task automatic test_flush();
      logic [63:0] r;
      int          lat;
      bit          os, seen;
      @(negedge clk);
      mul_div     = 1'b1;
      num1_signed = 1'b0;
      num2_signed = 1'b0;
      num1        = 32'h1234;
      num2        = 32'h5678;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      seen  = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL flush_ready: got 1 want 0");
      end
      n_checks++;
      if (result !== last_exp) begin
         n_fail++;
         $display("FAIL flush_result: got %h want %h", result, last_exp);
      end
      do_op(1'b1, 1'b0, 1'b0, 32'h6, 32'h7, r, lat, os);
      n_checks++;
      if (r !== 64'h2A) begin
         n_fail++;
         $display("FAIL after_flush result: got %h want %h", r, 64'h2A);
      end
      n_checks++;
      if (lat != MUL_LAT) begin
         n_fail++;
         $display("FAIL after_flush latency: got %0d want %0d",
                  lat, MUL_LAT);
      end
      last_exp = 64'h2A;
      @(negedge clk);
      mul_div = 1'b0;
      num1    = 32'h50;
      num2    = 32'h3;
      start   = 1'b1;
      flush   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      seen  = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (ready) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL flush_start_ready: got 1 want 0");
      end
      n_checks++;
      if (result !== last_exp) begin
         n_fail++;
         $display("FAIL flush_start_result: got %h want %h",
                  result, last_exp);
      end
   endtask

   task automatic test_async_reset();
      logic [63:0] r, e;
      int          lat;
      bit          os;
      @(negedge clk);
      mul_div = 1'b0;
      num1    = 32'h77;
      num2    = 32'h5;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if (result !== 64'h0) begin
         n_fail++;
         $display("FAIL async_reset_result: got %h want 0", result);
      end
      n_checks++;
      if (ready !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_ready: got %b want 0", ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      e = model(1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h7);
      do_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h7, r, lat, os);
      n_checks++;
      if (r !== e || lat != DIV_LAT) begin
         n_fail++;
         $display("FAIL post_reset_op: got %h lat %0d want %h lat %0d",
                  r, lat, e, DIV_LAT);
      end
      last_exp = e;
   endtask

   task automatic test_random();
      logic [63:0] r, e;
      logic [31:0] x, y;
      int          lat, want;
      bit          m, s1, s2, os;
      for (int i = 0; i < 60; i++) begin
         m  = 1'($urandom_range(0, 1));
         s1 = 1'($urandom_range(0, 1));
         s2 = 1'($urandom_range(0, 1));
         x  = pick();
         y  = pick();
         e  = model(m, s1, s2, x, y);
         want = m ? MUL_LAT : DIV_LAT;
         do_op(m, s1, s2, x, y, r, lat, os);
         n_checks++;
         if (r !== e) begin
            n_fail++;
            $display("FAIL rand_%0d %s s%0d%0d %h,%h: got %h want %h",
                     i, m ? "mul" : "div", s1, s2, x, y, r, e);
         end
         n_checks++;
         if (lat != want) begin
            n_fail++;
            $display("FAIL rand_%0d latency: got %0d want %0d",
                     i, lat, want);
         end
         n_checks++;
         if (!os) begin
            n_fail++;
            $display("FAIL rand_%0d pulse: got %b want 1", i, os);
         end
         last_exp = e;
      end
   endtask

   initial begin
      rstn        = 1'b0;
      flush       = 1'b0;
      start       = 1'b0;
      mul_div     = 1'b0;
      num1_signed = 1'b0;
      num2_signed = 1'b0;
      num1        = '0;
      num2        = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_directed();
      test_busy_ignore();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
